// File: rtl/vga_scan_gen.sv
// Parametrised VGA timing generator with framebuffer scan-out, pixel replication,
// RAM read-latency compensation and built-in test patterns (RGB444 output).
module vga_scan_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int SCALE_SHIFT = 1,
    parameter int RD_LAT      = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              clk25,
    input  logic              resetn,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] frame_addr,
    input  logic [11:0]       frame_pixel,
    output logic [3:0]        vga_red,
    output logic [3:0]        vga_green,
    output logic [3:0]        vga_blue,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_start
);

    localparam int HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W    = $clog2(HT + 1);
    localparam int V_W    = $clog2(VT + 1);
    localparam int REP    = 1 << SCALE_SHIFT;
    localparam int SRC_W  = H_ACTIVE >> SCALE_SHIFT;
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int BP_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int PIPE_D = RD_LAT + 1;
    localparam int GH_W   = (H_W < 5) ? H_W : 5;
    localparam int GV_W   = (V_W < 5) ? V_W : 5;

    localparam logic [H_W-1:0] H_LAST = H_W'(HT - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(VT - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] REP_MASK = V_W'(REP - 1);
    localparam logic [BP_W-1:0] BAR_LAST = BP_W'(BAR_W - 1);
    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       grid;
        logic [2:0] bar;
    } tap_t;

    logic [H_W-1:0]    h_reg;
    logic [V_W-1:0]    v_reg;
    logic [V_W-1:0]    v_plus1;
    logic [ADDR_W-1:0] line_base_reg;
    logic [ADDR_W-1:0] frame_addr_reg;
    logic [BP_W-1:0]   bar_pos_reg;
    logic [2:0]        bar_idx_reg;
    logic [1:0]        mode_reg;
    logic              h_last;
    logic              v_last;
    logic              active;
    logic              line_step;
    tap_t              tap_cur;
    tap_t              tap_out;
    logic [11:0]       pix;

    assign h_last  = (h_reg == H_LAST);
    assign v_last  = (v_reg == V_LAST);
    assign v_plus1 = v_reg + V_W'(1);
    assign active  = (h_reg < H_ACT) && (v_reg < V_ACT);
    // Advance the line base only when the next line starts a new source row.
    assign line_step = ((v_plus1 & REP_MASK) == '0) && (v_plus1 < V_ACT);

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            h_reg <= '0;
            v_reg <= '0;
        end else if (h_last) begin
            h_reg <= '0;
            v_reg <= v_last ? '0 : v_plus1;
        end else begin
            h_reg <= h_reg + H_W'(1);
        end
    end

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            line_base_reg <= '0;
        end else if (h_last) begin
            if (v_last) begin
                line_base_reg <= '0;
            end else if (line_step) begin
                line_base_reg <= line_base_reg + ADDR_W'(SRC_W);
            end
        end
    end

    // Source x index is h with the replication bits dropped.
    always_ff @(posedge clk25) begin
        if (!resetn) begin
            frame_addr_reg <= '0;
        end else if (active) begin
            frame_addr_reg <= line_base_reg + ADDR_W'(h_reg >> SCALE_SHIFT);
        end else if (v_reg >= V_ACT) begin
            frame_addr_reg <= '0;
        end
    end

    assign frame_addr = frame_addr_reg;

    // Colour-bar column tracker, avoids dividing h by the bar width.
    always_ff @(posedge clk25) begin
        if (!resetn || h_last) begin
            bar_pos_reg <= '0;
            bar_idx_reg <= '0;
        end else if (bar_pos_reg == BAR_LAST) begin
            bar_pos_reg <= '0;
            bar_idx_reg <= bar_idx_reg + 3'd1;
        end else begin
            bar_pos_reg <= bar_pos_reg + BP_W'(1);
        end
    end

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            mode_reg <= 2'd0;
        end else if (h_last && v_last) begin
            mode_reg <= mode;
        end
    end

    always_comb begin
        tap_cur        = '0;
        tap_cur.active = active;
        tap_cur.hs     = (h_reg >= HS_BEG) && (h_reg < HS_END);
        tap_cur.vs     = (v_reg >= VS_BEG) && (v_reg < VS_END);
        tap_cur.fs     = (h_reg == '0) && (v_reg == '0);
        tap_cur.grid   = (h_reg[GH_W-1:0] == '0) || (v_reg[GV_W-1:0] == '0);
        tap_cur.bar    = bar_idx_reg;
    end

    // Timing taps travel alongside the address and RAM read so every pin lines up.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_D; gi++) begin : g_pipe
            tap_t stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk25) begin
                    if (!resetn) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= tap_cur;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk25) begin
                    if (!resetn) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_pipe[gi-1].stage_reg;
                    end
                end
            end
        end
    endgenerate

    assign tap_out = g_pipe[PIPE_D-1].stage_reg;

    always_comb begin
        pix = 12'h000;
        case (mode_reg)
            2'd0: pix = frame_pixel;
            2'd1: begin
                case (tap_out.bar)
                    3'd0:    pix = 12'hFFF;
                    3'd1:    pix = 12'hFF0;
                    3'd2:    pix = 12'h0FF;
                    3'd3:    pix = 12'h0F0;
                    3'd4:    pix = 12'hF0F;
                    3'd5:    pix = 12'hF00;
                    3'd6:    pix = 12'h00F;
                    default: pix = 12'h000;
                endcase
            end
            2'd2:    pix = tap_out.grid ? 12'hFFF : 12'h000;
            default: pix = 12'h000;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            vga_red     <= 4'h0;
            vga_green   <= 4'h0;
            vga_blue    <= 4'h0;
            vga_hsync   <= ~HS_ON;
            vga_vsync   <= ~VS_ON;
            frame_start <= 1'b0;
        end else begin
            {vga_red, vga_green, vga_blue} <= tap_out.active ? pix : 12'h000;
            vga_hsync   <= tap_out.hs ? HS_ON : ~HS_ON;
            vga_vsync   <= tap_out.vs ? VS_ON : ~VS_ON;
            frame_start <= tap_out.fs;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen on a tiny 16x8 raster (S=2, RD_LAT=2, positive hsync).
module tb_vga_scan_gen;

    localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 8, VF = 1, VSW = 1, VB = 2;
    localparam int SS = 2, RL = 2, AW = 8;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FR = HT * VT;
    localparam int L  = RL + 2;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } pins_t;

    typedef struct {
        logic [1:0] md;
        int         cycles;
        int         exp_fs;
        int         exp_hs;
    } phase_t;

    localparam pins_t IDLE = {12'h000, 1'b0, 1'b1, 1'b0};

    logic          clk25 = 1'b0;
    logic          resetn = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] frame_addr;
    logic [11:0]   frame_pixel;
    logic [3:0]    vga_red, vga_green, vga_blue;
    logic          vga_hsync, vga_vsync, frame_start;

    vga_scan_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HSYNC_POL(1), .VSYNC_POL(0), .SCALE_SHIFT(SS), .RD_LAT(RL), .ADDR_W(AW)
    ) dut (
        .clk25(clk25), .resetn(resetn), .mode(mode),
        .frame_addr(frame_addr), .frame_pixel(frame_pixel),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
    );

    always #5 clk25 = ~clk25;

    function automatic logic [11:0] ram_fn(input logic [AW-1:0] a);
        return {a[3:0] ^ 4'hA, a[7:4] ^ 4'h3, a[3:0]};
    endfunction

    // RAM with RL cycles of read latency
    logic [11:0] ram_q [RL];
    always @(posedge clk25) begin
        ram_q[0] <= ram_fn(frame_addr);
        for (int k = 1; k < RL; k++) ram_q[k] <= ram_q[k-1];
    end
    assign frame_pixel = ram_q[RL-1];

    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    int addr_tab [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};

    pins_t         sb_q [$];
    int            mh, mv;
    logic [1:0]    mmode;
    logic [AW-1:0] maddr;
    int            n_vec = 0;
    int            n_bad = 0;

    function automatic pins_t model_pins(input int h, input int v, input logic [1:0] md);
        pins_t p;
        int a;
        p.hs  = (h >= HA + HF) && (h < HA + HF + HSW);
        p.vs  = !((v >= VA + VF) && (v < VA + VF + VSW));
        p.fs  = (h == 0) && (v == 0);
        p.rgb = 12'h000;
        if (h < HA && v < VA) begin
            case (md)
                2'd0: begin
                    a = (v >> SS) * (HA >> SS) + (h >> SS);
                    p.rgb = ram_fn(AW'(a));
                end
                2'd1:    p.rgb = bar_tab[h / (HA / 8)];
                2'd2:    p.rgb = ((h % 32) == 0 || (v % 32) == 0) ? 12'hFFF : 12'h000;
                default: p.rgb = 12'h000;
            endcase
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d, t=%0t)",
                     name, act, exp, mh, mv, $time);
        end
    endtask

    // One clock: advance the model for the coming edge, then compare after it.
    task automatic cycle();
        pins_t got, want;
        logic in_rst;
        in_rst = !resetn;
        if (in_rst) begin
            mh = 0; mv = 0; mmode = 2'd0; maddr = '0;
            sb_q.delete();
            repeat (L) sb_q.push_back(IDLE);
        end else begin
            if (mh < HA && mv < VA) maddr = AW'((mv >> SS) * (HA >> SS) + (mh >> SS));
            else if (mv >= VA) maddr = '0;
            if (mh == HT - 1 && mv == VT - 1) mmode = mode;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        sb_q.push_back(model_pins(mh, mv, mmode));
        @(posedge clk25);
        #1;
        want = sb_q.pop_front();
        got  = {vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start};
        check(in_rst ? "reset_pins" : "pins", 32'(got), 32'(want));
        check(in_rst ? "reset_addr" : "frame_addr", 32'(frame_addr), 32'(maddr));
        $display("t=%0t h=%0d v=%0d mode=%0d addr=%0d rgb=%03h hs=%0b vs=%0b fs=%0b",
                 $time, mh, mv, mmode, frame_addr, {vga_red, vga_green, vga_blue},
                 vga_hsync, vga_vsync, frame_start);
    endtask

    phase_t ph [5];

    initial begin
        int fs_cnt, hs_cnt, first_fs;
        logic hs_prev;

        ph[0] = '{2'd0, 2 * FR, 2, 2 * VT};
        ph[1] = '{2'd2, FR, 1, VT};
        ph[2] = '{2'd1, 2 * FR, 2, 2 * VT};
        ph[3] = '{2'd3, FR, 1, VT};
        ph[4] = '{2'd0, FR, 1, VT};

        resetn = 1'b0;
        repeat (3) cycle();
        resetn = 1'b1;
        hs_prev = 1'b0;

        for (int p = 0; p < 5; p++) begin
            fs_cnt = 0;
            hs_cnt = 0;
            mode = ph[p].md;
            for (int c = 0; c < ph[p].cycles; c++) begin
                cycle();
                if (frame_start) fs_cnt++;
                if (vga_hsync && !hs_prev) hs_cnt++;
                hs_prev = vga_hsync;
            end
            check($sformatf("phase%0d_frame_starts", p), 32'(fs_cnt), 32'(ph[p].exp_fs));
            check($sformatf("phase%0d_hsync_pulses", p), 32'(hs_cnt), 32'(ph[p].exp_hs));
        end

        // Reset for a single cycle in the middle of an active line.
        for (int k = 0; k < FR && !(mh == 10 && mv == 3); k++) cycle();
        resetn = 1'b0;
        cycle();
        check("rst_rgb", 32'({vga_red, vga_green, vga_blue}), 32'h0);
        check("rst_hsync", 32'(vga_hsync), 32'h0);
        check("rst_vsync", 32'(vga_vsync), 32'h1);
        resetn = 1'b1;

        first_fs = -1;
        for (int c = 1; c <= FR + 16; c++) begin
            cycle();
            if (c <= 16) check($sformatf("line0_addr%0d", c - 1), 32'(frame_addr), 32'(addr_tab[c - 1]));
            if (frame_start && first_fs < 0) first_fs = c;
        end
        check("frame_start_after_reset", 32'(first_fs), 32'(L));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
